// File: rtl/rom_read_arbiter.sv
// rom_read_arbiter: shares one synchronous-read ROM between NUM_REQ requesters.
// Requests are granted one per cycle. Each granted read carries its requester
// index through a ROM_LATENCY-deep tag pipeline, so the returning rom_dout can
// be steered to the right requester.
// Build option: define ROM_ARB_FIXED_PRIO_EN to get fixed-priority arbitration
// (lowest valid index wins, no rotating pointer). Undefined gives round-robin.
module rom_read_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int ROM_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]         resp_data,
  output logic [ADDR_WIDTH-1:0]         rom_addr,
  input  logic [DATA_WIDTH-1:0]         rom_dout
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  typedef logic [IDX_W-1:0] idx_t;

  logic [NUM_REQ-1:0]    grant_s;
  idx_t                  gidx_s;
  logic                  hs_s;

  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [ROM_LATENCY-1:0] tag_vld_q, tag_vld_d;
  idx_t                  tag_id_q [ROM_LATENCY];
  idx_t                  tag_id_d [ROM_LATENCY];

`ifndef ROM_ARB_FIXED_PRIO_EN
  idx_t                  ptr_q, ptr_d;
`endif

  // Arbitration: pick the first valid requester, starting at the priority pointer.
  always_comb begin : arb_comb
    int   cand;
    idx_t cand_i;
    grant_s = '0;
    gidx_s  = '0;
    hs_s    = 1'b0;
    cand    = 0;
    cand_i  = '0;
    if (en && !rst) begin
      for (int off = 0; off < NUM_REQ; off++) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
        cand = off;
`else
        cand = (int'(ptr_q) + off) % NUM_REQ;
`endif
        cand_i = idx_t'(cand);
        if (!hs_s && req_valid[cand_i]) begin
          grant_s[cand_i] = 1'b1;
          gidx_s          = cand_i;
          hs_s            = 1'b1;
        end else begin
          hs_s = hs_s;
        end
      end
    end else begin
      grant_s = '0;
    end
  end

  assign req_ready = grant_s;

`ifndef ROM_ARB_FIXED_PRIO_EN
  // Next pointer: the requester just after the winner gets top priority.
  always_comb begin
    ptr_d = ptr_q;
    if (hs_s) begin
      if (gidx_s == idx_t'(NUM_REQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = gidx_s + idx_t'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Next ROM address: the winner's address on a handshake, otherwise hold.
  always_comb begin
    rom_addr_d = rom_addr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_s[i]) begin
        rom_addr_d = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end else begin
        rom_addr_d = rom_addr_d;
      end
    end
  end

  // Tag pipeline next state: stage 0 takes this cycle's grant, the rest shift.
  always_comb begin
    tag_vld_d    = '0;
    tag_vld_d[0] = hs_s;
    tag_id_d[0]  = gidx_s;
    for (int i = 1; i < ROM_LATENCY; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end
  end

  // ROM address and tag pipeline registers; reset discards in-flight reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr_q <= '0;
      tag_vld_q  <= '0;
      for (int i = 0; i < ROM_LATENCY; i++) begin
        tag_id_q[i] <= '0;
      end
    end else begin
      rom_addr_q <= rom_addr_d;
      tag_vld_q  <= tag_vld_d;
      for (int i = 0; i < ROM_LATENCY; i++) begin
        tag_id_q[i] <= tag_id_d[i];
      end
    end
  end

  assign rom_addr = rom_addr_q;

  // Response steering: ROM data passes straight through to the tagged requester.
  always_comb begin
    resp_valid = '0;
    resp_data  = '0;
    if (tag_vld_q[ROM_LATENCY-1] && !rst) begin
      resp_valid[tag_id_q[ROM_LATENCY-1]] = 1'b1;
      resp_data                           = rom_dout;
    end else begin
      resp_valid = '0;
      resp_data  = '0;
    end
  end

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Bench for rom_read_arbiter: four instances (ROM_LATENCY 1..4) share one
// stimulus stream. A reference arbiter queues the expected response of every
// grant; a monitor matches each instance's responses against that queue.
module tb_rom_read_arbiter;

  localparam int NI = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  req_valid;
  logic [31:0] req_addr;

  logic [3:0]  ready_a [NI];
  logic [3:0]  rv_a    [NI];
  logic [7:0]  rd_a    [NI];
  logic [7:0]  ra_a    [NI];
  logic [7:0]  dout_a  [NI];

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_f(input logic [7:0] a);
    return {a[3:0], a[7:4]} ^ 8'h5A;
  endfunction

  generate
    for (genvar k = 0; k < NI; k++) begin : g_dut
      localparam int L = k + 1;
      rom_read_arbiter #(
        .NUM_REQ(4), .ADDR_WIDTH(8), .DATA_WIDTH(8), .ROM_LATENCY(L)
      ) u_dut (
        .clk(clk), .rst(rst), .en(en),
        .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(ready_a[k]), .resp_valid(rv_a[k]), .resp_data(rd_a[k]),
        .rom_addr(ra_a[k]), .rom_dout(dout_a[k])
      );
      if (L == 1) begin : g_rom1
        assign dout_a[k] = rom_f(ra_a[k]);
      end else begin : g_romn
        logic [7:0] dly [L-1];
        always @(posedge clk) begin
          dly[0] <= ra_a[k];
          for (int i = 1; i < L - 1; i++) dly[i] <= dly[i-1];
        end
        assign dout_a[k] = rom_f(dly[L-2]);
      end
    end
  endgenerate

  typedef struct packed {
    logic [1:0]  tag;
    logic [7:0]  data;
    logic [31:0] cyc;
  } exp_t;

  exp_t exp_q[$];
  int   rd_idx [NI] = '{default: 0};
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   m_ptr = 0;
  logic chk_zero  = 1'b0;
  logic chk_drain = 1'b0;
  logic drained   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d got=%0h want=%0h cyc=%0d", nm, inst, act, exp, cyc);
    end
  endtask

  // Reference arbiter + response monitor, evaluated mid-cycle.
  always @(negedge clk) begin
    logic [3:0] eg;
    int         gi;
    int         j;
    int         due;
    exp_t       e;
    eg = 4'b0;
    gi = 0;
    j  = 0;
    if (rst) begin
      m_ptr = 0;
      for (int k = 0; k < NI; k++) rd_idx[k] = exp_q.size();
    end else if (en) begin
      for (int i = 0; i < 4; i++) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
        j = i;
`else
        j = (m_ptr + i) % 4;
`endif
        if (eg == 4'b0 && req_valid[j]) begin
          eg[j] = 1'b1;
          gi    = j;
        end
      end
    end
    for (int k = 0; k < NI; k++) check("grant", k, ready_a[k], eg);
    if (eg != 4'b0) begin
      e.tag  = gi[1:0];
      e.data = rom_f(req_addr[gi*8 +: 8]);
      e.cyc  = cyc;
      exp_q.push_back(e);
`ifndef ROM_ARB_FIXED_PRIO_EN
      m_ptr = (gi + 1) % 4;
`endif
    end
    for (int k = 0; k < NI; k++) begin
      if (rv_a[k] != 4'b0) begin
        if (rd_idx[k] >= exp_q.size()) begin
          check("resp_unexpected", k, rv_a[k], 4'b0);
        end else begin
          e = exp_q[rd_idx[k]];
          check("resp_tag", k, rv_a[k], 4'b1 << e.tag);
          check("resp_data", k, rd_a[k], e.data);
          check("resp_latency", k, cyc - e.cyc, k + 1);
          rd_idx[k]++;
        end
      end else begin
        check("resp_data_idle", k, rd_a[k], 8'h00);
        if (rd_idx[k] < exp_q.size()) begin
          e   = exp_q[rd_idx[k]];
          due = int'(e.cyc) + k + 1;
          if (due <= cyc) begin
            check("resp_missing", k, rv_a[k], 4'b1 << e.tag);
            rd_idx[k]++;
          end
        end
      end
    end
    if (chk_zero) begin
      for (int k = 0; k < NI; k++) check("rom_addr_after_reset", k, ra_a[k], 8'h00);
    end
    if (chk_drain) begin
      for (int k = 0; k < NI; k++) check("all_responses_seen", k, rd_idx[k], exp_q.size());
      drained = 1'b1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; req_valid = 4'b0; req_addr = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_zero = 1'b1;
    step(1);
    chk_zero = 1'b0;

    // Enable gating, then round-robin with everyone valid.
    req_addr  = {8'h40, 8'h30, 8'h20, 8'h10};
    req_valid = 4'b1111;
    step(10);
    en = 1'b1;
    step(12);
    req_valid = 4'b0;
    step(3);

    // Single requester streaming every address back-to-back.
    req_valid = 4'b0100;
    for (int a = 0; a < 256; a++) begin
      req_addr[23:16] = 8'(a);
      step(1);
    end
    req_valid = 4'b0;
    step(4);

    // Alternating requesters 0 and 3.
    req_addr  = {8'hC3, 8'h00, 8'h00, 8'h3C};
    req_valid = 4'b1001;
    step(8);
    req_valid = 4'b0;
    step(5);

    // Enable drops with reads in flight.
    req_addr  = {8'hE1, 8'hD2, 8'hC3, 8'hB4};
    req_valid = 4'b1111;
    step(2);
    en = 1'b0;
    step(6);
    en = 1'b1;
    step(4);
    req_valid = 4'b0;
    step(3);

    // Reset right after a grant to requester 1.
    req_addr  = 32'h0000_5500;
    req_valid = 4'b0010;
    step(1);
    req_valid = 4'b0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    chk_zero = 1'b1;
    step(1);
    chk_zero = 1'b0;

    // First grant after reset goes to the lowest valid index.
    req_addr  = {8'h77, 8'h00, 8'h66, 8'h00};
    req_valid = 4'b1010;
    step(4);
    req_valid = 4'b0;
    step(2);

    // Requesters 0 and 1 both continuously valid.
    req_addr  = {8'h00, 8'h00, 8'h99, 8'h88};
    req_valid = 4'b0011;
    step(8);
    req_valid = 4'b0;
    step(8);

    chk_drain = 1'b1;
    for (int i = 0; i < 20 && !drained; i++) @(posedge clk);
    chk_drain = 1'b0;
    if (!drained) begin
      $display("FAIL drain_timeout monitor did not finish");
      $fatal(1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
